// File: rtl/ser_bus_pkg.sv
// Shared command/response codes and frame-decoder state encoding for ser_bus_master.
package ser_bus_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h2E;
  localparam logic [7:0] RSP_ERR = 8'h3F;
  localparam logic [7:0] RSP_TMO = 8'h21;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StBus,
    StReply
  } state_e;

endpackage

// File: rtl/sbm_reply.sv
// Reply serialiser: holds 1 or 4 bytes and hands them to the transmitter MSB first.
module sbm_reply (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        four,
  input  logic [31:0] data,
  input  logic        tx_rdy,
  output logic        tx_wr,
  output logic [7:0]  tx_data,
  output logic        done
);

  logic [31:0] sh_q;
  logic [2:0]  rem_q;

  assign tx_wr   = (rem_q != 3'd0) & tx_rdy;
  assign tx_data = sh_q[31:24];
  // Asserted while the final byte is being handed over.
  assign done    = tx_wr & (rem_q == 3'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      rem_q <= '0;
    end else if (load) begin
      sh_q  <= data;
      rem_q <= four ? 3'd4 : 3'd1;
    end else if (tx_wr) begin
      sh_q  <= {sh_q[23:0], 8'h00};
      rem_q <= rem_q - 3'd1;
    end
  end

endmodule

// File: rtl/ser_bus_master.sv
// Serial-command bus initiator: decodes W/R frames into stb/we/ack bus cycles.
// Optional ack timeout enabled by defining SBM_TIMEOUT_EN.
module ser_bus_master
  import ser_bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = 24,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              rx_rd,
  input  logic              tx_rdy,
  output logic              tx_wr,
  output logic [7:0]        tx_data,
  output logic              bus_stb,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_dout,
  input  logic [31:0]       bus_din,
  input  logic              bus_ack,
  output logic              busy
);

  state_e            state_q;
  logic [1:0]        cnt_q;
  logic              is_wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       dout_q;
  logic              stb_q;
  logic              we_q;

  logic              rpl_load;
  logic              rpl_four;
  logic [31:0]       rpl_data;
  logic              rpl_done;
  logic              tmo_hit;

`ifdef SBM_TIMEOUT_EN
  localparam int unsigned TmoW = ($clog2(TIMEOUT) > 10) ? $clog2(TIMEOUT) : 10;
  logic [TmoW-1:0] tmo_q;
  assign tmo_hit = (state_q == StBus) && !bus_ack && (tmo_q == TmoW'(TIMEOUT - 1));
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT;
  assign tmo_hit    = 1'b0;
`endif

  assign rx_rd    = ~rst & rx_rdy & (state_q inside {StIdle, StAddr, StData});
  assign bus_stb  = stb_q;
  assign bus_we   = we_q;
  assign bus_addr = addr_q;
  assign bus_dout = dout_q;
  assign busy     = (state_q != StIdle);

  always_comb begin
    rpl_load = 1'b0;
    rpl_four = 1'b0;
    rpl_data = '0;
    if (state_q == StIdle && rx_rd && rx_data != CMD_WR && rx_data != CMD_RD) begin
      rpl_load = 1'b1;
      rpl_data = {RSP_ERR, 24'h0};
    end else if (state_q == StBus && bus_ack) begin
      // Read data is captured straight into the reply shifter.
      rpl_load = 1'b1;
      rpl_four = ~is_wr_q;
      rpl_data = is_wr_q ? {RSP_OK, 24'h0} : bus_din;
    end else if (tmo_hit) begin
      rpl_load = 1'b1;
      rpl_data = {RSP_TMO, 24'h0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
`ifdef SBM_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
`ifdef SBM_TIMEOUT_EN
      tmo_q <= (state_q == StBus) ? tmo_q + 1'b1 : '0;
`endif
      unique case (state_q)
        StIdle: begin
          if (rx_rd) begin
            cnt_q <= '0;
            if (rx_data == CMD_WR) begin
              is_wr_q <= 1'b1;
              state_q <= StAddr;
            end else if (rx_data == CMD_RD) begin
              is_wr_q <= 1'b0;
              state_q <= StAddr;
            end else begin
              state_q <= StReply;
            end
          end
        end
        StAddr: begin
          if (rx_rd) begin
            // Upper address bits fall off the top of the shifter.
            addr_q <= ADDR_W'({addr_q, rx_data});
            cnt_q  <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              if (is_wr_q) begin
                state_q <= StData;
              end else begin
                state_q <= StBus;
                stb_q   <= 1'b1;
                we_q    <= 1'b0;
              end
            end
          end
        end
        StData: begin
          if (rx_rd) begin
            dout_q <= {dout_q[23:0], rx_data};
            cnt_q  <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              state_q <= StBus;
              stb_q   <= 1'b1;
              we_q    <= 1'b1;
            end
          end
        end
        StBus: begin
          if (bus_ack || tmo_hit) begin
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= StReply;
          end
        end
        StReply: begin
          if (rpl_done) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  sbm_reply u_reply (
    .clk     (clk),
    .rst     (rst),
    .load    (rpl_load),
    .four    (rpl_four),
    .data    (rpl_data),
    .tx_rdy  (tx_rdy),
    .tx_wr   (tx_wr),
    .tx_data (tx_data),
    .done    (rpl_done)
  );

endmodule

// File: tb/tb_ser_bus_master.sv
// Directed bench for ser_bus_master: write/read frames, bad command, tx stall, reset, timeout.
module tb_ser_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_rd;
  logic        tx_rdy;
  logic        tx_wr;
  logic [7:0]  tx_data;
  logic        bus_stb;
  logic        bus_we;
  logic [23:0] bus_addr;
  logic [31:0] bus_dout;
  logic [31:0] bus_din = 32'h80030183;
  logic        bus_ack;
  logic        busy;

  logic        tx_hold = 1'b0;
  logic        ack_on = 1'b1;
  int          ack_delay = 0;
  int          stb_cnt = 0;

  int          n_checks = 0;
  int          n_fail = 0;
  int          stb_cycles, wr_cycles, rx_rd_cnt;
  logic [23:0] last_addr;
  logic        last_we;
  logic [31:0] last_dout;
  logic [7:0]  tx_q[$];

  always #5 clk = ~clk;

  ser_bus_master #(
    .ADDR_W  (24),
    .TIMEOUT (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_rdy   (rx_rdy),
    .rx_data  (rx_data),
    .rx_rd    (rx_rd),
    .tx_rdy   (tx_rdy),
    .tx_wr    (tx_wr),
    .tx_data  (tx_data),
    .bus_stb  (bus_stb),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_dout (bus_dout),
    .bus_din  (bus_din),
    .bus_ack  (bus_ack),
    .busy     (busy)
  );

  // Responder: ack once stb has been high for ack_delay full cycles.
  assign bus_ack = ack_on && bus_stb && (stb_cnt >= ack_delay);
  assign tx_rdy  = ~tx_hold;

  always @(posedge clk) stb_cnt <= bus_stb ? stb_cnt + 1 : 0;

  always @(negedge clk) begin
    if (bus_stb) begin
      stb_cycles++;
      last_addr = bus_addr;
      last_we   = bus_we;
      last_dout = bus_dout;
      if (bus_we) wr_cycles++;
    end
    if (rx_rd) rx_rd_cnt++;
    if (tx_wr) tx_q.push_back(tx_data);
  end

  task automatic clr();
    stb_cycles = 0;
    wr_cycles  = 0;
    rx_rd_cnt  = 0;
    last_addr  = '0;
    last_we    = 1'b0;
    last_dout  = '0;
    tx_q.delete();
  endtask

  function automatic logic [31:0] tx_word();
    if (tx_q.size() == 4) return {tx_q[0], tx_q[1], tx_q[2], tx_q[3]};
    return 32'hxxxxxxxx;
  endfunction

  task automatic pulse_rst();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    rx_data = b;
    rx_rdy  = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rx_rd) break;
    end
    if (k == 50) begin
      n_checks++; n_fail++;
      $display("FAIL rx_consume: byte %02h not taken, required rx_rd within 50 cycles", b);
    end
    @(posedge clk); #1 rx_rdy = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [31:0] a);
    send_byte(cmd);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
  endtask

  task automatic send_w(input logic [31:0] a, input logic [31:0] d);
    send_hdr(8'h57, a);
    for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (k == 300) begin
      n_checks++; n_fail++;
      $display("FAIL wait_idle: busy still 1 after 300 cycles, required 0");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    pulse_rst();
    @(negedge clk);
    n_checks++;
    if ({rx_rd, tx_wr, bus_stb, bus_we, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: rd/wr/stb/we/busy=%b required 00000",
               {rx_rd, tx_wr, bus_stb, bus_we, busy});
    end
    n_checks++;
    if (bus_addr !== 24'h0 || bus_dout !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_bus: addr=%h dout=%h required 0/0", bus_addr, bus_dout);
    end
    n_checks++;
    if (tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_txdata: got %h required 00", tx_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    clr(); ack_on = 1'b1; ack_delay = 0;
    send_w(32'h00000004, 32'h000000A5);
    n_checks++;
    if (bus_stb !== 1'b1 || bus_we !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_latency: stb=%b we=%b one cycle after last byte, required 1/1",
               bus_stb, bus_we);
    end
    wait_idle();
    n_checks++;
    if (stb_cycles != 1) begin
      n_fail++; $display("FAIL wr_stb_len: got %0d cycles required 1", stb_cycles);
    end
    n_checks++;
    if (last_addr !== 24'h000004 || last_dout !== 32'h000000A5 || last_we !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_bus: addr=%h dout=%h we=%b required 000004/000000a5/1",
               last_addr, last_dout, last_we);
    end
    n_checks++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h2E) begin
      n_fail++; $display("FAIL wr_reply: %0d bytes first=%h required 1 byte 2e",
                         tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx);
    end
    n_checks++;
    if (rx_rd_cnt != 9) begin
      n_fail++; $display("FAIL wr_rxcount: got %0d required 9", rx_rd_cnt);
    end
  endtask

  task automatic test_read();
    clr(); ack_on = 1'b1; ack_delay = 3;
    send_hdr(8'h52, 32'h00000004);
    wait_idle();
    n_checks++;
    if (stb_cycles != 4) begin
      n_fail++; $display("FAIL rd_stb_len: got %0d cycles required 4", stb_cycles);
    end
    n_checks++;
    if (last_we !== 1'b0 || last_addr !== 24'h000004 || wr_cycles != 0) begin
      n_fail++; $display("FAIL rd_bus: we=%b addr=%h wr_cycles=%0d required 0/000004/0",
                         last_we, last_addr, wr_cycles);
    end
    n_checks++;
    if (tx_word() !== 32'h80030183) begin
      n_fail++; $display("FAIL rd_reply: %0d bytes word=%h required 80030183",
                         tx_q.size(), tx_word());
    end
  endtask

  task automatic test_bad_cmd();
    clr();
    send_byte(8'h41);
    wait_idle();
    n_checks++;
    if (rx_rd_cnt != 1 || stb_cycles != 0) begin
      n_fail++; $display("FAIL bad_cmd: rx_rd=%0d stb=%0d required 1/0", rx_rd_cnt, stb_cycles);
    end
    n_checks++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h3F) begin
      n_fail++; $display("FAIL bad_reply: %0d bytes first=%h required 1 byte 3f",
                         tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL bad_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_tx_stall();
    clr(); ack_on = 1'b1; ack_delay = 0;
    tx_hold = 1'b1;
    send_hdr(8'h52, 32'h00000004);
    repeat (20) @(negedge clk);
    n_checks++;
    if (tx_q.size() != 0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL stall_hold: %0d bytes busy=%b required 0 bytes busy 1",
                         tx_q.size(), busy);
    end
    @(posedge clk); #1 tx_hold = 1'b0;
    wait_idle();
    n_checks++;
    if (tx_word() !== 32'h80030183) begin
      n_fail++; $display("FAIL stall_resume: %0d bytes word=%h required 80030183",
                         tx_q.size(), tx_word());
    end
  endtask

  task automatic test_rst_midframe();
    clr(); ack_on = 1'b1; ack_delay = 0;
    send_byte(8'h57);
    for (int i = 0; i < 3; i++) send_byte(8'h00);
    pulse_rst();
    n_checks++;
    if (busy !== 1'b0 || bus_stb !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid: busy=%b stb=%b required 0/0", busy, bus_stb);
    end
    clr();
    send_hdr(8'h52, 32'h00000008);
    wait_idle();
    n_checks++;
    if (wr_cycles != 0 || stb_cycles != 1 || last_addr !== 24'h000008) begin
      n_fail++; $display("FAIL rst_read: wr=%0d stb=%0d addr=%h required 0/1/000008",
                         wr_cycles, stb_cycles, last_addr);
    end
    n_checks++;
    if (tx_word() !== 32'h80030183) begin
      n_fail++; $display("FAIL rst_reply: word=%h required 80030183", tx_word());
    end
  endtask

  task automatic test_timeout();
    clr(); ack_on = 1'b0;
    send_w(32'h00000010, 32'h00001234);
`ifdef SBM_TIMEOUT_EN
    wait_idle();
    n_checks++;
    if (stb_cycles != 16) begin
      n_fail++; $display("FAIL tmo_len: got %0d stb cycles required 16", stb_cycles);
    end
    n_checks++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h21) begin
      n_fail++; $display("FAIL tmo_reply: %0d bytes first=%h required 1 byte 21",
                         tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx);
    end
`else
    repeat (40) @(negedge clk);
    n_checks++;
    if (bus_stb !== 1'b1 || tx_q.size() != 0) begin
      n_fail++; $display("FAIL no_tmo: stb=%b tx=%0d after 40 cycles required 1/0",
                         bus_stb, tx_q.size());
    end
    pulse_rst();
    n_checks++;
    if (bus_stb !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL no_tmo_rst: stb=%b busy=%b required 0/0", bus_stb, busy);
    end
`endif
    ack_on = 1'b1;
  endtask

  initial begin
    clr();
    test_reset();
    test_write();
    test_read();
    test_bad_cmd();
    test_tx_stall();
    test_rst_midframe();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
